sd_mod_gen: RTL and testbench

SD_MOD_GEN -- requirements
Module: sd_mod_gen

---
 rtl/sd_mod_gen.sv | 83 ++++++++
 tb/tb_sd_mod_gen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_mod_gen.sv
// sd_mod_gen: first/second-order sigma-delta modulator with a one-entry sample slot
// that is loaded into the loop once per OSR-tick frame.
module sd_mod_gen #(
  parameter int BW    = 16,
  parameter int ORDER = 2,
  parameter int IW    = BW + 4,
  parameter int DIV   = 1,
  parameter int OSR   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic signed [BW-1:0] sd_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 bs_out,
  output logic                 bs_valid,
  output logic                 ovf,
  output logic                 urun,
  input  logic                 flag_clr
);
  localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int FW = OSR > 1 ? $clog2(OSR) : 1;
  localparam int SW = IW + 2;
  localparam logic signed [SW-1:0] SMAX = {3'b000, {(IW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {3'b111, {(IW-1){1'b0}}};
  localparam logic signed [IW-1:0] IMAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] IMIN = {1'b1, {(IW-1){1'b0}}};
  localparam logic signed [SW-1:0] FB_P = {{(SW-BW){1'b0}}, 1'b1, {(BW-1){1'b0}}};
  localparam logic signed [SW-1:0] FB_N = {{(SW-BW+1){1'b1}}, {(BW-1){1'b0}}};
  logic [TW-1:0] tcnt;
  logic [FW-1:0] fcnt;
  logic signed [BW-1:0] x, pend, x_use;
  logic pend_full;
  logic signed [IW-1:0] i1, i2, i1_n, i2_n;
  logic signed [SW-1:0] fb, s1, s2;
  logic tick, fstart, xfer, accept, sat1, sat2;
  assign in_ready = ~pend_full;
  // Sums are formed two bits wider than the integrators so clamping sees the true value.
  always_comb begin
    tick   = en && tcnt == TW'(DIV - 1);
    fstart = tick && fcnt == '0;
    xfer   = fstart && pend_full;
    accept = in_valid && ~pend_full;
    x_use  = xfer ? pend : x;
    fb     = bs_out ? FB_P : FB_N;
    s1     = {{2{i1[IW-1]}}, i1} + {{(SW-BW){x_use[BW-1]}}, x_use} - fb;
    sat1   = s1 > SMAX || s1 < SMIN;
    i1_n   = s1 > SMAX ? IMAX : s1 < SMIN ? IMIN : s1[IW-1:0];
    s2     = {{2{i1_n[IW-1]}}, i1_n} + {{2{i2[IW-1]}}, i2} - fb;
    sat2   = ORDER == 2 && (s2 > SMAX || s2 < SMIN);
    i2_n   = ORDER == 1 ? i2 : s2 > SMAX ? IMAX : s2 < SMIN ? IMIN : s2[IW-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt      <= '0;
      fcnt      <= '0;
      x         <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      i1        <= '0;
      i2        <= '0;
      bs_out    <= 1'b0;
      bs_valid  <= 1'b0;
      ovf       <= 1'b0;
      urun      <= 1'b0;
    end else begin
      bs_valid <= tick;
      if (en) tcnt <= tcnt == TW'(DIV - 1) ? '0 : tcnt + 1'b1;
      if (tick) begin
        fcnt   <= fcnt == FW'(OSR - 1) ? '0 : fcnt + 1'b1;
        x      <= x_use;
        i1     <= i1_n;
        i2     <= i2_n;
        bs_out <= ~(ORDER == 1 ? i1_n[IW-1] : i2_n[IW-1]);
      end
      if (accept) pend <= sd_in;
      pend_full <= accept | (pend_full & ~xfer);
      ovf       <= (tick & (sat1 | sat2)) | (ovf & ~flag_clr);
      urun      <= (fstart & ~pend_full) | (urun & ~flag_clr);
    end
  end
endmodule

// File: tb/tb_sd_mod_gen.sv
// tb_sd_mod_gen: randomized self-checking bench; instance a uses defaults, instance b
// uses IW=17/DIV=3, both compared against a tick-level integer model.
module tb_sd_mod_gen;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, in_valid = 1'b0, flag_clr = 1'b0;
  logic signed [15:0] sd_in = '0;
  logic [1:0] rdy, bs, bv, ov, ur;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sd_mod_gen dut_a (.clk(clk), .rst_n(rst_n), .en(en), .sd_in(sd_in), .in_valid(in_valid),
    .in_ready(rdy[0]), .bs_out(bs[0]), .bs_valid(bv[0]), .ovf(ov[0]), .urun(ur[0]),
    .flag_clr(flag_clr));
  sd_mod_gen #(.IW(17), .DIV(3)) dut_b (.clk(clk), .rst_n(rst_n), .en(en), .sd_in(sd_in),
    .in_valid(in_valid), .in_ready(rdy[1]), .bs_out(bs[1]), .bs_valid(bv[1]), .ovf(ov[1]),
    .urun(ur[1]), .flag_clr(flag_clr));

  int m_i1[2], m_i2[2], m_x[2], m_pend[2], m_tc[2], m_fc[2];
  bit m_full[2], m_bs[2], m_bv[2], m_ovf[2], m_urun[2];
  bit t_tk, t_acc, t_sat, t_und;
  int t_fb, t_l, t_v1, t_v2;

  function automatic int dv(input int k);
    return k == 0 ? 1 : 3;
  endfunction
  function automatic int lim(input int k);
    return k == 0 ? 524287 : 65535;
  endfunction
  function automatic int clip(input int v, input int l);
    return v > l ? l : v < -l - 1 ? -l - 1 : v;
  endfunction

  // Model advances on the same edge as the DUTs; inputs only change on negedges.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_i1[k] = 0; m_i2[k] = 0; m_x[k] = 0; m_pend[k] = 0; m_tc[k] = 0; m_fc[k] = 0;
        m_full[k] = 0; m_bs[k] = 0; m_bv[k] = 0; m_ovf[k] = 0; m_urun[k] = 0;
      end else begin
        t_tk  = en && m_tc[k] == dv(k) - 1;
        t_acc = in_valid && !m_full[k];
        t_sat = 0;
        t_und = 0;
        if (t_tk) begin
          if (m_fc[k] == 0) begin
            if (m_full[k]) begin
              m_x[k] = m_pend[k];
              m_full[k] = 0;
            end else t_und = 1;
          end
          t_fb = m_bs[k] ? 32768 : -32768;
          t_l  = lim(k);
          t_v1 = m_i1[k] + m_x[k] - t_fb;
          m_i1[k] = clip(t_v1, t_l);
          t_v2 = m_i2[k] + m_i1[k] - t_fb;
          m_i2[k] = clip(t_v2, t_l);
          t_sat = t_v1 != m_i1[k] || t_v2 != m_i2[k];
          m_bs[k] = m_i2[k] >= 0;
          m_fc[k] = (m_fc[k] + 1) % 4;
        end
        m_bv[k] = t_tk;
        if (en) m_tc[k] = (m_tc[k] + 1) % dv(k);
        if (t_acc) begin
          m_pend[k] = sd_in;
          m_full[k] = 1;
        end
        m_ovf[k]  = t_sat || (m_ovf[k] && !flag_clr);
        m_urun[k] = t_und || (m_urun[k] && !flag_clr);
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst_n = 0; en = 0; in_valid = 0; flag_clr = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 0; en = 1; in_valid = 1; flag_clr = 0; sd_in = 16'(int'($urandom));
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bs[k], bv[k], rdy[k], ov[k], ur[k]} !== 5'b00100) begin
        failures++;
        $display("FAIL reset_outputs k=%0d got=%b exp=00100", k, {bs[k], bv[k], rdy[k], ov[k], ur[k]});
      end
    end
    checks++;
    if (int'(dut_a.i1) !== 0 || int'(dut_a.i2) !== 0 || int'(dut_b.i1) !== 0) begin
      failures++;
      $display("FAIL reset_integrators got a.i1=%0d a.i2=%0d b.i1=%0d exp=0", dut_a.i1, dut_a.i2, dut_b.i1);
    end
    rst_n = 1;
  endtask

  task automatic test_dc(input string name, input int v, input int lo, input int hi);
    int ones = 0, n = 0;
    do_reset();
    sd_in = 16'(v);
    in_valid = 1;
    @(negedge clk);
    en = 1;
    for (int c = 0; c < 1000 && n < 4 * (hi + lo) / 2 * 0 + (v == 0 ? 64 : 256); c++) begin
      @(negedge clk);
      checks++;
      if ({bs[0], bv[0]} !== {m_bs[0], m_bv[0]}) begin
        failures++;
        $display("FAIL %s_stream got=%b exp=%b", name, {bs[0], bv[0]}, {m_bs[0], m_bv[0]});
      end
      if (bv[0] === 1'b1) begin
        n++;
        ones += int'(bs[0]);
      end
    end
    checks++;
    if (n != (v == 0 ? 64 : 256)) begin
      failures++;
      $display("FAIL %s_tick_budget got=%0d ticks", name, n);
    end
    checks++;
    if (ones < lo || ones > hi) begin
      failures++;
      $display("FAIL %s_ones got=%0d exp=%0d..%0d", name, ones, lo, hi);
    end
    checks++;
    if (ov[0] !== 1'b0 && v == 0 || ur[0] !== 1'b0) begin
      failures++;
      $display("FAIL %s_flags got ovf=%b urun=%b exp=0", name, ov[0], ur[0]);
    end
    en = 0;
  endtask

  task automatic test_random;
    int r;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({bs[k], bv[k], rdy[k], ov[k], ur[k]} !== {m_bs[k], m_bv[k], !m_full[k], m_ovf[k], m_urun[k]}) begin
          failures++;
          $display("FAIL random_outputs k=%0d cyc=%0d got=%b exp=%b", k, c, {bs[k], bv[k], rdy[k], ov[k], ur[k]},
                   {m_bs[k], m_bv[k], !m_full[k], m_ovf[k], m_urun[k]});
        end
      end
      checks++;
      if (int'(dut_a.i1) !== m_i1[0] || int'(dut_a.i2) !== m_i2[0] ||
          int'(dut_b.i1) !== m_i1[1] || int'(dut_b.i2) !== m_i2[1]) begin
        failures++;
        $display("FAIL random_integrators cyc=%0d got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d", c, dut_a.i1, dut_a.i2,
                 dut_b.i1, dut_b.i2, m_i1[0], m_i2[0], m_i1[1], m_i2[1]);
      end
      r = int'($urandom_range(0, 65535)) - 32768;
      sd_in = 16'(r);
      en = $urandom_range(0, 7) != 0;
      in_valid = $urandom_range(0, 2) != 0;
      flag_clr = $urandom_range(0, 15) == 0;
      rst_n = $urandom_range(0, 199) != 0;
    end
    rst_n = 1; flag_clr = 0; en = 0;
  endtask

  task automatic test_en_gap;
    int last, strobes, s1, s2;
    do_reset();
    sd_in = 16'sd3000;
    in_valid = 1;
    @(negedge clk);
    en = 1;
    for (int p = 0; p < 2; p++) begin
      last = -1;
      strobes = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (bv[1] === 1'b1) begin
          strobes++;
          if (last >= 0) begin
            checks++;
            if (c - last != 3) begin
              failures++;
              $display("FAIL gap_spacing phase=%0d got=%0d exp=3", p, c - last);
            end
          end
          last = c;
        end
      end
      checks++;
      if (strobes < 9) begin
        failures++;
        $display("FAIL gap_strobes phase=%0d got=%0d exp>=9", p, strobes);
      end
      if (p == 0) begin
        s1 = m_i1[1];
        s2 = m_i2[1];
        en = 0;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (bv[1] !== 1'b0 || int'(dut_b.i1) !== s1 || int'(dut_b.i2) !== s2) begin
            failures++;
            $display("FAIL gap_hold got bv=%b i1=%0d i2=%0d exp bv=0 i1=%0d i2=%0d", bv[1], dut_b.i1, dut_b.i2, s1, s2);
          end
        end
        en = 1;
      end
    end
    en = 0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    sd_in = 16'sd100;
    in_valid = 1;
    @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready_drop got=%b exp=0", rdy[0]);
    end
    sd_in = 16'sd200;
    en = 1;
    @(negedge clk);
    checks++;
    if (int'(dut_a.x) !== 100 || rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_transfer got x=%0d rdy=%b exp x=100 rdy=1", dut_a.x, rdy[0]);
    end
    @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept got rdy=%b exp=0", rdy[0]);
    end
    in_valid = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (int'(dut_a.x) !== 200 || ur[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_transfer got x=%0d urun=%b exp x=200 urun=0", dut_a.x, ur[0]);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (ur[0] !== 1'b1 || rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_underrun got urun=%b rdy=%b exp urun=1 rdy=1", ur[0], rdy[0]);
    end
    en = 0;
    flag_clr = 1;
    @(negedge clk);
    flag_clr = 0;
    checks++;
    if (ur[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_flag_clr got urun=%b exp=0", ur[0]);
    end
  endtask

  task automatic test_saturate;
    int n = 0;
    do_reset();
    sd_in = 16'sd32767;
    in_valid = 1;
    @(negedge clk);
    en = 1;
    for (int c = 0; c < 3300 && n < 1000; c++) begin
      @(negedge clk);
      if (bv[1] === 1'b1) n++;
      checks++;
      if (int'(dut_b.i1) !== m_i1[1] || int'(dut_b.i2) !== m_i2[1]) begin
        failures++;
        $display("FAIL sat_integrators cyc=%0d got=%0d,%0d exp=%0d,%0d", c, dut_b.i1, dut_b.i2, m_i1[1], m_i2[1]);
      end
    end
    checks++;
    if (n != 1000 || ov[1] !== 1'b1) begin
      failures++;
      $display("FAIL sat_ovf got ticks=%0d ovf=%b exp ticks=1000 ovf=1", n, ov[1]);
    end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bs[k], bv[k], rdy[k], ov[k], ur[k]} !== 5'b00100) begin
        failures++;
        $display("FAIL midrun_reset k=%0d got=%b exp=00100", k, {bs[k], bv[k], rdy[k], ov[k], ur[k]});
      end
    end
    checks++;
    if (int'(dut_b.i1) !== 0 || int'(dut_b.i2) !== 0 || int'(dut_b.x) !== 0) begin
      failures++;
      $display("FAIL midrun_reset_state got i1=%0d i2=%0d x=%0d exp=0", dut_b.i1, dut_b.i2, dut_b.x);
    end
    en = 0;
  endtask

  initial begin
    test_reset();
    test_dc("zero", 0, 31, 33);
    test_dc("pos_half", 16384, 190, 194);
    test_dc("neg_half", -16384, 62, 66);
    test_random();
    test_en_gap();
    test_back_to_back();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
